// File: rtl/dma_pkt_pkg.sv
// Shared definitions for the DMA TX packet reader: header field positions,
// FSM state encoding and the last-word byte-enable helper.
package dma_pkt_pkg;

  localparam int unsigned BYTES_PER_WORD = 8;
  localparam int unsigned LEN_LSB        = 0;
  localparam int unsigned LEN_MSB        = 15;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SF,
    XFER,
    DRAIN,
    DROP
  } state_t;

  // Enable for the final word; a length that is a multiple of 8 fills it completely.
  function automatic logic [7:0] last_be(input logic [2:0] len);
    logic [7:0] be;
    be = 8'hFF;
    if (len != 3'd0) be = (8'h01 << len) - 8'h01;
    return be;
  endfunction

endpackage

// File: rtl/AXI_clks.sv
// Clock/reset bundle shared by the TX datapath blocks; rst is active-low.
interface AXI_clks;
  logic clk;
  logic rst;
  modport to_rtl (input clk, input rst);
endinterface

// File: rtl/dma_tx_out_stage.sv
// Output holding register for the TX stream: loads a word when told to and
// holds it stable until the MAC accepts it.
module dma_tx_out_stage #(
  parameter int unsigned DWIDTH = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DWIDTH-1:0] din,
  input  logic              sop_in,
  input  logic              eop_in,
  input  logic [7:0]        be_in,
  input  logic              tx_ready,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_valid,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [7:0]        tx_be
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      tx_sop   <= 1'b0;
      tx_eop   <= 1'b0;
      tx_be    <= '0;
    end else if (load) begin
      tx_data  <= din;
      tx_valid <= 1'b1;
      tx_sop   <= sop_in;
      tx_eop   <= eop_in;
      tx_be    <= be_in;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/dma_tx_pkt_reader.sv
// Ethernet MAC TX packet reader: parses a one-word length header from the packet DMA FIFO,
// streams the payload with SOP/EOP/byte enables, drops illegal lengths. DMA_TX_STORE_FWD_EN selects store-and-forward.
module dma_tx_pkt_reader
  import dma_pkt_pkg::*;
#(
  parameter int unsigned DWIDTH     = 64,
  parameter int unsigned AWIDTH     = 8,
  parameter int unsigned FIFO_DEPTH = 1 << AWIDTH,
  parameter int unsigned MAX_LEN    = 1518
) (
  AXI_clks.to_rtl           clks,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              fifo_empty,
  input  logic [AWIDTH:0]   fifo_depth_left,
  output logic              fifo_pull,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic [7:0]        tx_be,
  output logic              pkt_done,
  output logic              len_err,
  output logic [31:0]       pkt_cnt,
  output logic [15:0]       err_cnt
);

  if (DWIDTH != 8 * BYTES_PER_WORD) begin : g_bad_width
    $error("dma_tx_pkt_reader: only DWIDTH=64 is supported");
  end
  if ((MAX_LEN + BYTES_PER_WORD - 1) / BYTES_PER_WORD + 1 > FIFO_DEPTH) begin : g_bad_depth
    $error("dma_tx_pkt_reader: FIFO_DEPTH cannot hold a maximum-length packet plus header");
  end

  logic        clk;
  logic        rst_n;
  state_t      state, state_nx;
  logic [13:0] rem_q, rem_nx;
  logic        first_q, first_nx;
  logic [7:0]  be_q, be_nx;
  logic        pull, load, done_nx, err_nx, accept;
  logic [15:0] hdr_len;
  logic [16:0] len_rnd;
  logic [13:0] nwords;

  assign clk     = clks.clk;
  assign rst_n   = clks.rst;
  assign hdr_len = fifo_data[LEN_MSB:LEN_LSB];
  assign len_rnd = {1'b0, hdr_len} + 17'd7;
  assign nwords  = len_rnd[16:3];
  assign accept  = tx_valid & tx_ready;

`ifdef DMA_TX_STORE_FWD_EN
  logic [AWIDTH:0] fifo_used;
  assign fifo_used = (AWIDTH+1)'(FIFO_DEPTH) - fifo_depth_left;
`else
  logic unused_depth_left;
  assign unused_depth_left = ^fifo_depth_left;
`endif

  always_comb begin
    state_nx = state;
    rem_nx   = rem_q;
    first_nx = first_q;
    be_nx    = be_q;
    pull     = 1'b0;
    load     = 1'b0;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pull = 1'b1;
          if (hdr_len == 16'd0) begin
            err_nx = 1'b1;
          end else if ({16'd0, hdr_len} > MAX_LEN) begin
            err_nx   = 1'b1;
            rem_nx   = nwords;
            state_nx = DROP;
          end else begin
            rem_nx   = nwords;
            first_nx = 1'b1;
            be_nx    = last_be(hdr_len[2:0]);
`ifdef DMA_TX_STORE_FWD_EN
            state_nx = WAIT_SF;
`else
            state_nx = XFER;
`endif
          end
        end
      end
`ifdef DMA_TX_STORE_FWD_EN
      WAIT_SF: begin
        if (32'(fifo_used) >= 32'(rem_q)) state_nx = XFER;
      end
`endif
      XFER: begin
        load = !fifo_empty && (!tx_valid || tx_ready);
        pull = load;
        if (load) begin
          rem_nx   = rem_q - 14'd1;
          first_nx = 1'b0;
          if (rem_q == 14'd1) state_nx = DRAIN;
        end
      end
      // Returning to IDLE only after acceptance keeps the next header pull off the EOP handshake cycle.
      DRAIN: begin
        if (accept) begin
          done_nx  = 1'b1;
          state_nx = IDLE;
        end
      end
      DROP: begin
        if (!fifo_empty) begin
          pull   = 1'b1;
          rem_nx = rem_q - 14'd1;
          if (rem_q == 14'd1) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Gated by reset so the pop strobe drops at once, even before the FIFO's own reset empties it.
  assign fifo_pull = pull & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rem_q    <= '0;
      first_q  <= 1'b0;
      be_q     <= '1;
      pkt_done <= 1'b0;
      len_err  <= 1'b0;
      pkt_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nx;
      rem_q    <= rem_nx;
      first_q  <= first_nx;
      be_q     <= be_nx;
      pkt_done <= done_nx;
      len_err  <= err_nx;
      if (done_nx) pkt_cnt <= pkt_cnt + 32'd1;
      if (err_nx && err_cnt != '1) err_cnt <= err_cnt + 16'd1;
    end
  end

  dma_tx_out_stage #(.DWIDTH(DWIDTH)) u_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .din      (fifo_data),
    .sop_in   (first_q),
    .eop_in   (rem_q == 14'd1),
    .be_in    ((rem_q == 14'd1) ? be_q : 8'hFF),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_sop   (tx_sop),
    .tx_eop   (tx_eop),
    .tx_be    (tx_be)
  );

endmodule

// File: tb/tb_dma_tx_pkt_reader.sv
// Bench for dma_tx_pkt_reader: FIFO model plus packet-level reference queue of expected beats.
module tb_dma_tx_pkt_reader;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned MAXL   = 1518;
  localparam int          BUDGET = 20000;

  typedef struct packed {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [7:0]  be;
  } beat_t;

  AXI_clks clks_if ();

  logic [63:0] fifo_data       = '0;
  logic        fifo_empty      = 1'b1;
  logic [8:0]  fifo_depth_left = 9'd256;
  logic        fifo_pull;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready        = 1'b0;
  logic        tx_sop, tx_eop;
  logic [7:0]  tx_be;
  logic        pkt_done, len_err;
  logic [31:0] pkt_cnt;
  logic [15:0] err_cnt;

  dma_tx_pkt_reader #(.DWIDTH(64), .AWIDTH(8), .FIFO_DEPTH(256), .MAX_LEN(1518)) dut (
    .clks            (clks_if),
    .fifo_data       (fifo_data),
    .fifo_empty      (fifo_empty),
    .fifo_depth_left (fifo_depth_left),
    .fifo_pull       (fifo_pull),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_sop          (tx_sop),
    .tx_eop          (tx_eop),
    .tx_be           (tx_be),
    .pkt_done        (pkt_done),
    .len_err         (len_err),
    .pkt_cnt         (pkt_cnt),
    .err_cnt         (err_cnt)
  );

  initial clks_if.clk = 1'b0;
  always #5 clks_if.clk = ~clks_if.clk;

  logic [63:0] fq[$];
  logic [63:0] push_q[$];
  logic [63:0] src[$];
  beat_t       exp_q[$];
  beat_t       obs[$];
  logic        do_pop = 1'b0;

  int n_chk = 0, n_err = 0;
  int n_done, n_lerr, n_pull, n_pull_empty, n_pull_stall, n_hold, n_eop_stall, n_bubble;
  int exp_done, exp_lerr;
  logic [31:0] exp_pkt_tot;
  logic [15:0] exp_err_tot;

  // Show-ahead FIFO: pops and staged writes take effect at the clock edge.
  always @(posedge clks_if.clk or negedge clks_if.rst) begin
    if (!clks_if.rst) begin
      fq.delete();
    end else begin
      if (do_pop && fq.size() > 0) void'(fq.pop_front());
      while (push_q.size() > 0) fq.push_back(push_q.pop_front());
    end
    fifo_empty      <= (fq.size() == 0);
    fifo_data       <= (fq.size() == 0) ? 64'd0 : fq[0];
    fifo_depth_left <= 9'(DEPTH - fq.size());
  end

  // Monitor samples 1 time unit before each rising edge.
  beat_t cur_b, prev_b;
  logic  prev_stall = 1'b0, in_pkt = 1'b0;
  always begin
    @(negedge clks_if.clk);
    #4;
    do_pop = fifo_pull;
    cur_b  = {tx_data, tx_sop, tx_eop, tx_be};
    if (clks_if.rst) begin
      if (fifo_pull) n_pull++;
      if (fifo_pull && fifo_empty) n_pull_empty++;
      if (fifo_pull && tx_valid && !tx_ready) n_pull_stall++;
      if (pkt_done) n_done++;
      if (len_err) n_lerr++;
      if (prev_stall && (!tx_valid || cur_b != prev_b)) n_hold++;
      if (tx_valid && tx_eop && !tx_ready) n_eop_stall++;
      if (in_pkt && !tx_valid) n_bubble++;
      if (tx_valid && tx_ready) begin
        obs.push_back(cur_b);
        if (tx_sop && !tx_eop) in_pkt = 1'b1;
        if (tx_eop) in_pkt = 1'b0;
      end
      prev_stall = tx_valid && !tx_ready;
      prev_b     = cur_b;
    end else begin
      prev_stall = 1'b0;
      in_pkt     = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_chk++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clear_run();
    obs.delete();
    exp_q.delete();
    n_done = 0; n_lerr = 0; n_pull = 0; n_pull_empty = 0; n_pull_stall = 0;
    n_hold = 0; n_eop_stall = 0; n_bubble = 0; exp_done = 0; exp_lerr = 0;
  endtask

  // Reference: header carries len; ceil(len/8) payload words follow; illegal lengths yield no beats.
  task automatic add_pkt(input int unsigned len);
    logic [63:0]  w;
    beat_t        b;
    int unsigned  n;
    w = {$urandom, $urandom};
    w[15:0] = len[15:0];
    src.push_back(w);
    n = (len + 7) / 8;
    for (int unsigned i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      src.push_back(w);
      if (len <= MAXL) begin
        b.d   = w;
        b.sop = (i == 0);
        b.eop = (i == n - 1);
        b.be  = 8'hFF;
        if (i == n - 1 && len % 8 != 0) b.be = 8'((1 << (len % 8)) - 1);
        exp_q.push_back(b);
      end
    end
    if (len != 0 && len <= MAXL) begin
      exp_done++;
      exp_pkt_tot++;
    end else begin
      exp_lerr++;
      if (exp_err_tot != 16'hFFFF) exp_err_tot++;
    end
  endtask

  // push_every=0 preloads everything; mode 0: ready=1, 1: random ready, 2: stall the EOP beat 4 cycles.
  task automatic run(input string tag, input int push_every, input int mode);
    int cyc = 0, idle = 0, stall = 0;
    while (cyc < BUDGET) begin
      @(negedge clks_if.clk);
      if (push_every == 0) begin
        while (src.size() > 0) push_q.push_back(src.pop_front());
      end else if (src.size() > 0 && cyc % push_every == 0 &&
                   fq.size() + push_q.size() < DEPTH) begin
        push_q.push_back(src.pop_front());
      end
      case (mode)
        1:       tx_ready = 1'($urandom_range(0, 1));
        2: begin
          if (tx_valid && tx_eop && stall < 4) begin
            tx_ready = 1'b0;
            stall++;
          end else tx_ready = 1'b1;
        end
        default: tx_ready = 1'b1;
      endcase
      cyc++;
      if (src.size() == 0 && push_q.size() == 0 && fifo_empty && !tx_valid) idle++;
      else idle = 0;
      if (idle >= 4) break;
    end
    chk({tag, ":finished_in_budget"}, cyc < BUDGET, 1'b1);
  endtask

  task automatic verify(input string tag);
    chk({tag, ":beat_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      chk({tag, ":beat"}, obs[i], exp_q[i]);
    chk({tag, ":pkt_done_pulses"}, n_done, exp_done);
    chk({tag, ":len_err_pulses"}, n_lerr, exp_lerr);
    chk({tag, ":pkt_cnt"}, pkt_cnt, exp_pkt_tot);
    chk({tag, ":err_cnt"}, err_cnt, exp_err_tot);
    chk({tag, ":pull_while_empty"}, n_pull_empty, 0);
    chk({tag, ":pull_while_stalled"}, n_pull_stall, 0);
    chk({tag, ":held_word_changed"}, n_hold, 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, ":tx_valid"}, tx_valid, 1'b0);
    chk({tag, ":tx_sop"}, tx_sop, 1'b0);
    chk({tag, ":tx_eop"}, tx_eop, 1'b0);
    chk({tag, ":fifo_pull"}, fifo_pull, 1'b0);
    chk({tag, ":pkt_done"}, pkt_done, 1'b0);
    chk({tag, ":len_err"}, len_err, 1'b0);
    chk({tag, ":tx_data"}, tx_data, 64'd0);
    chk({tag, ":tx_be"}, tx_be, 8'd0);
    chk({tag, ":pkt_cnt"}, pkt_cnt, 32'd0);
    chk({tag, ":err_cnt"}, err_cnt, 16'd0);
  endtask

  initial begin
    int cyc;
    exp_pkt_tot = '0;
    exp_err_tot = '0;
    clear_run();
    clks_if.rst = 1'b0;
    repeat (3) @(negedge clks_if.clk);
    chk_zero_outputs("reset");
    clks_if.rst = 1'b1;
    @(negedge clks_if.clk);

    clear_run();
    add_pkt(16);
    run("len16", 0, 0);
    chk("len16:pull_cycles", n_pull, 3);
    verify("len16");

    clear_run();
    add_pkt(13);
    run("len13_stall", 0, 2);
    chk("len13_stall:eop_stall_cycles", n_eop_stall, 4);
    chk("len13_stall:pull_cycles", n_pull, 3);
    verify("len13_stall");

    clear_run();
    add_pkt(0);
    add_pkt(8);
    run("len0_len8", 1, 0);
    verify("len0_len8");

    clear_run();
    add_pkt(2000);
    add_pkt(8);
    run("drop2000", 1, 0);
    chk("drop2000:pull_cycles", n_pull, 1 + 250 + 1 + 1);
    verify("drop2000");

    clear_run();
    add_pkt(24);
    run("slow_fill", 3, 0);
`ifdef DMA_TX_STORE_FWD_EN
    chk("slow_fill:no_bubbles", n_bubble, 0);
`else
    chk("slow_fill:has_bubbles", n_bubble > 0, 1'b1);
`endif
    verify("slow_fill");

    clear_run();
    add_pkt(1518);
    add_pkt(1519);
    for (int k = 0; k < 16; k++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 12)      add_pkt(0);
      else if (r < 24) add_pkt($urandom_range(1519, 1560));
      else             add_pkt($urandom_range(1, 200));
    end
    run("random", $urandom_range(1, 2), 1);
    verify("random");

    clear_run();
    add_pkt(24);
    push_q = src;
    src.delete();
    tx_ready = 1'b1;
    cyc = 0;
    while (obs.size() == 0 && cyc < 200) begin
      @(negedge clks_if.clk);
      cyc++;
    end
    chk("midrst:first_beat_seen", obs.size() != 0, 1'b1);
    clks_if.rst = 1'b0;
    #1;
    chk_zero_outputs("midrst");
    push_q.delete();
    src.delete();
    exp_pkt_tot = '0;
    exp_err_tot = '0;
    clear_run();
    repeat (2) @(negedge clks_if.clk);
    clks_if.rst = 1'b1;
    @(negedge clks_if.clk);
    add_pkt(8);
    run("after_rst", 1, 0);
    verify("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
